// File: rtl/gbe_rx_stats_pkg.sv
// Shared types and constants for the 10GbE receive statistics monitor.
// Wrap-flag indices give the bit order of the packed ctr_wrapped vector.
package gbe_rx_stats_pkg;

  localparam int CTR_W_DEF = 32;
  localparam int LEN_W_DEF = 16;

  localparam int WRAP_VLD = 0;
  localparam int WRAP_EOF = 1;
  localparam int WRAP_BAD = 2;
  localparam int WRAP_OF  = 3;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } frame_state_e;

endpackage

// File: rtl/gbe_rx_event_counter.sv
// Free-running event counter with clear, enable and a sticky wrap flag.
// The flag sets when the count rolls over from all-ones to zero.
module gbe_rx_event_counter
  import gbe_rx_stats_pkg::*;
#(
  parameter int CTR_W = CTR_W_DEF
) (
  input  logic             user_clk,
  input  logic             user_rst,
  input  logic             clr,
  input  logic             en,
  input  logic             inc,
  output logic [CTR_W-1:0] count,
  output logic             wrapped
);

  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      count   <= '0;
      wrapped <= 1'b0;
    end else if (clr) begin
      count   <= '0;
      wrapped <= 1'b0;
    end else if (en && inc) begin
      count <= count + CTR_ONE;
      if (&count) wrapped <= 1'b1;
    end
  end

endmodule

// File: rtl/gbe_rx_stats.sv
// Passive monitor of the 10GbE core receive interface: word, end-of-frame,
// bad-frame and overrun counters plus last/maximum frame length.
module gbe_rx_stats
  import gbe_rx_stats_pkg::*;
#(
  parameter int CTR_W = CTR_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             user_clk,
  input  logic             user_rst,
  input  logic             rx_valid,
  input  logic             rx_end_of_frame,
  input  logic             rx_bad_frame,
  input  logic             rx_overrun,
  input  logic             ctr_en,
  input  logic             ctr_clr,
  output logic [CTR_W-1:0] rxvldctr,
  output logic [CTR_W-1:0] rxeofctr,
  output logic [CTR_W-1:0] rxbadctr,
  output logic [CTR_W-1:0] rxofctr,
  output logic [LEN_W-1:0] last_frame_len,
  output logic [LEN_W-1:0] max_frame_len,
  output logic [3:0]       ctr_wrapped
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  logic             ctr_clr_d;
  logic             rx_overrun_d;
  logic             clr_pulse;
  logic             of_rise;
  logic             inc_eof;
  logic             inc_bad;

  frame_state_e     state;
  frame_state_e     state_next;
  logic [LEN_W-1:0] frame_len;
  logic [LEN_W-1:0] frame_len_next;
  logic [LEN_W-1:0] len_inc;
  logic [LEN_W-1:0] done_len;
  logic             frame_done;

  logic             wrap_vld;
  logic             wrap_eof;
  logic             wrap_bad;
  logic             wrap_of;

  // Delayed copies reset to 0, so a level already high after reset is an edge.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      ctr_clr_d    <= 1'b0;
      rx_overrun_d <= 1'b0;
    end else begin
      ctr_clr_d    <= ctr_clr;
      rx_overrun_d <= rx_overrun;
    end
  end

  assign clr_pulse = ctr_clr & ~ctr_clr_d;
  assign of_rise   = rx_overrun & ~rx_overrun_d;
  assign inc_eof   = rx_valid & rx_end_of_frame;
  assign inc_bad   = rx_valid & rx_end_of_frame & rx_bad_frame;
  assign len_inc   = (&frame_len) ? frame_len : frame_len + LEN_ONE;

  // Frame tracking ignores ctr_en and the clear so a frame in progress completes.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state     <= IDLE;
      frame_len <= '0;
    end else begin
      state     <= state_next;
      frame_len <= frame_len_next;
    end
  end

  // NOTE: combinational blocks assign a default to every output first,
  // so no path can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    if (rx_valid) begin
      case (state)
        IDLE:     if (!rx_end_of_frame) state_next = IN_FRAME;
        IN_FRAME: if (rx_end_of_frame)  state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    frame_len_next = frame_len;
    frame_done     = 1'b0;
    done_len       = '0;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_end_of_frame) begin
            frame_done = 1'b1;
            done_len   = LEN_ONE;
          end else begin
            frame_len_next = LEN_ONE;
          end
        end
        IN_FRAME: begin
          if (rx_end_of_frame) begin
            frame_done = 1'b1;
            done_len   = len_inc;
          end else begin
            frame_len_next = len_inc;
          end
        end
        default: frame_len_next = '0;
      endcase
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      last_frame_len <= '0;
      max_frame_len  <= '0;
    end else if (clr_pulse) begin
      last_frame_len <= '0;
      max_frame_len  <= '0;
    end else if (ctr_en && frame_done) begin
      last_frame_len <= done_len;
      if (done_len > max_frame_len) max_frame_len <= done_len;
    end
  end

  gbe_rx_event_counter #(.CTR_W(CTR_W)) u_vld (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .clr      (clr_pulse),
    .en       (ctr_en),
    .inc      (rx_valid),
    .count    (rxvldctr),
    .wrapped  (wrap_vld)
  );

  gbe_rx_event_counter #(.CTR_W(CTR_W)) u_eof (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .clr      (clr_pulse),
    .en       (ctr_en),
    .inc      (inc_eof),
    .count    (rxeofctr),
    .wrapped  (wrap_eof)
  );

  gbe_rx_event_counter #(.CTR_W(CTR_W)) u_bad (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .clr      (clr_pulse),
    .en       (ctr_en),
    .inc      (inc_bad),
    .count    (rxbadctr),
    .wrapped  (wrap_bad)
  );

  gbe_rx_event_counter #(.CTR_W(CTR_W)) u_of (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .clr      (clr_pulse),
    .en       (ctr_en),
    .inc      (of_rise),
    .count    (rxofctr),
    .wrapped  (wrap_of)
  );

  always_comb begin
    ctr_wrapped           = '0;
    ctr_wrapped[WRAP_VLD] = wrap_vld;
    ctr_wrapped[WRAP_EOF] = wrap_eof;
    ctr_wrapped[WRAP_BAD] = wrap_bad;
    ctr_wrapped[WRAP_OF]  = wrap_of;
  end

endmodule

// File: tb/tb_gbe_rx_stats.sv
// Self-checking bench for gbe_rx_stats: directed scenarios followed by random
// traffic, all compared every cycle against a word/frame-level reference model.
module tb_gbe_rx_stats;
  import gbe_rx_stats_pkg::*;

  localparam int CTR_W   = 8;
  localparam int LEN_W   = 4;
  localparam int MOD     = 1 << CTR_W;
  localparam int LEN_MAX = (1 << LEN_W) - 1;

  logic             user_clk = 1'b0;
  logic             user_rst;
  logic             rx_valid;
  logic             rx_end_of_frame;
  logic             rx_bad_frame;
  logic             rx_overrun;
  logic             ctr_en;
  logic             ctr_clr;
  logic [CTR_W-1:0] rxvldctr;
  logic [CTR_W-1:0] rxeofctr;
  logic [CTR_W-1:0] rxbadctr;
  logic [CTR_W-1:0] rxofctr;
  logic [LEN_W-1:0] last_frame_len;
  logic [LEN_W-1:0] max_frame_len;
  logic [3:0]       ctr_wrapped;

  gbe_rx_stats #(.CTR_W(CTR_W), .LEN_W(LEN_W)) dut (
    .user_clk        (user_clk),
    .user_rst        (user_rst),
    .rx_valid        (rx_valid),
    .rx_end_of_frame (rx_end_of_frame),
    .rx_bad_frame    (rx_bad_frame),
    .rx_overrun      (rx_overrun),
    .ctr_en          (ctr_en),
    .ctr_clr         (ctr_clr),
    .rxvldctr        (rxvldctr),
    .rxeofctr        (rxeofctr),
    .rxbadctr        (rxbadctr),
    .rxofctr         (rxofctr),
    .last_frame_len  (last_frame_len),
    .max_frame_len   (max_frame_len),
    .ctr_wrapped     (ctr_wrapped)
  );

  always #5 user_clk = ~user_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: plain integers describing the statistics.
  int       m_vld, m_eof, m_bad, m_of, m_last, m_max;
  bit [3:0] m_wrap;
  int       words;
  bit       p_clr, p_ov;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic bump(inout int c, input int idx);
    if (c == MOD - 1) begin
      c = 0;
      m_wrap[idx] = 1'b1;
    end else begin
      c++;
    end
  endtask

  task automatic zero_stats();
    m_vld = 0; m_eof = 0; m_bad = 0; m_of = 0;
    m_last = 0; m_max = 0; m_wrap = '0;
  endtask

  task automatic model_edge();
    bit clr_p;
    bit ov_r;
    bit done;
    int len;
    clr_p = 1'b0; ov_r = 1'b0; done = 1'b0; len = 0;
    if (user_rst) begin
      zero_stats();
      words = 0;
      p_clr = 1'b0;
      p_ov  = 1'b0;
    end else begin
      clr_p = ctr_clr && !p_clr;
      ov_r  = rx_overrun && !p_ov;
      if (rx_valid) begin
        words++;
        if (rx_end_of_frame) begin
          done  = 1'b1;
          len   = (words > LEN_MAX) ? LEN_MAX : words;
          words = 0;
        end
      end
      if (clr_p) begin
        zero_stats();
      end else if (ctr_en) begin
        if (rx_valid) bump(m_vld, WRAP_VLD);
        if (rx_valid && rx_end_of_frame) bump(m_eof, WRAP_EOF);
        if (rx_valid && rx_end_of_frame && rx_bad_frame) bump(m_bad, WRAP_BAD);
        if (ov_r) bump(m_of, WRAP_OF);
        if (done) begin
          m_last = len;
          if (len > m_max) m_max = len;
        end
      end
      p_clr = ctr_clr;
      p_ov  = rx_overrun;
    end
  endtask

  task automatic check_all();
    check("rxvldctr", 32'(rxvldctr), 32'(m_vld));
    check("rxeofctr", 32'(rxeofctr), 32'(m_eof));
    check("rxbadctr", 32'(rxbadctr), 32'(m_bad));
    check("rxofctr", 32'(rxofctr), 32'(m_of));
    check("last_frame_len", 32'(last_frame_len), 32'(m_last));
    check("max_frame_len", 32'(max_frame_len), 32'(m_max));
    check("ctr_wrapped", 32'(ctr_wrapped), 32'(m_wrap));
  endtask

  // One clock: inputs are already driven; compare 1 time unit after the edge.
  task automatic step();
    @(posedge user_clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic send_frame(input int n, input bit bad);
    for (int i = 0; i < n; i++) begin
      rx_valid        = 1'b1;
      rx_end_of_frame = (i == n - 1);
      rx_bad_frame    = bad && (i == n - 1);
      step();
    end
    rx_valid        = 1'b0;
    rx_end_of_frame = 1'b0;
    rx_bad_frame    = 1'b0;
  endtask

  task automatic pulse_clear();
    ctr_clr = 1'b1;
    step();
    ctr_clr = 1'b0;
    step();
  endtask

  initial begin
    zero_stats();
    words = 0; p_clr = 1'b0; p_ov = 1'b0;
    user_rst = 1'b1; rx_valid = 1'b1; rx_end_of_frame = 1'b0;
    rx_bad_frame = 1'b0; rx_overrun = 1'b0; ctr_en = 1'b1; ctr_clr = 1'b0;

    // Reset held with traffic present
    repeat (3) step();
    check("rst_vld", 32'(rxvldctr), 32'd0);
    check("rst_last", 32'(last_frame_len), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    user_rst = 1'b0;
    rx_valid = 1'b0;
    step();

    // Back-to-back frames of 5, 1 and 9 words
    send_frame(5, 1'b0);
    send_frame(1, 1'b0);
    send_frame(9, 1'b0);
    step();
    check("seq_vld", 32'(rxvldctr), 32'd15);
    check("seq_eof", 32'(rxeofctr), 32'd3);
    check("seq_last", 32'(last_frame_len), 32'd9);
    check("seq_max", 32'(max_frame_len), 32'd9);

    // Bad frame with a long overrun level
    pulse_clear();
    rx_overrun = 1'b1;
    send_frame(4, 1'b1);
    repeat (6) step();
    rx_overrun = 1'b0;
    step();
    check("bad_bad", 32'(rxbadctr), 32'd1);
    check("bad_eof", 32'(rxeofctr), 32'd1);
    check("bad_of", 32'(rxofctr), 32'd1);
    check("bad_last", 32'(last_frame_len), 32'd4);

    // Clear raised on word 3 of a 6-word frame
    for (int i = 0; i < 6; i++) begin
      rx_valid        = 1'b1;
      rx_end_of_frame = (i == 5);
      ctr_clr         = (i >= 2);
      step();
      if (i == 2) begin
        check("clr_vld_zero", 32'(rxvldctr), 32'd0);
        check("clr_bad_zero", 32'(rxbadctr), 32'd0);
      end
    end
    rx_valid = 1'b0; rx_end_of_frame = 1'b0; ctr_clr = 1'b0;
    step();
    check("clr_vld", 32'(rxvldctr), 32'd3);
    check("clr_eof", 32'(rxeofctr), 32'd1);
    check("clr_last", 32'(last_frame_len), 32'd6);

    // Counter wrap and frame-length saturation in one long frame
    pulse_clear();
    send_frame(MOD + 1, 1'b0);
    step();
    check("wrap_vld", 32'(rxvldctr), 32'd1);
    check("wrap_flag", 32'(ctr_wrapped), 32'b0001);
    check("wrap_last_sat", 32'(last_frame_len), 32'(LEN_MAX));

    // Counting disabled for a whole frame, then re-enabled
    ctr_en = 1'b0;
    send_frame(7, 1'b0);
    step();
    check("dis_vld", 32'(rxvldctr), 32'd1);
    check("dis_last", 32'(last_frame_len), 32'(LEN_MAX));
    ctr_en = 1'b1;
    send_frame(2, 1'b0);
    step();
    check("en_vld", 32'(rxvldctr), 32'd3);
    check("en_last", 32'(last_frame_len), 32'd2);
    check("en_max", 32'(max_frame_len), 32'(LEN_MAX));

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      user_rst        = ($urandom_range(0, 249) == 0);
      rx_valid        = ($urandom_range(0, 3) != 0);
      rx_end_of_frame = ($urandom_range(0, 6) == 0);
      rx_bad_frame    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) rx_overrun = ~rx_overrun;
      if ($urandom_range(0, 49) == 0) ctr_clr = ~ctr_clr;
      ctr_en          = ($urandom_range(0, 9) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gbe_rx_stats.md
# gbe_rx_stats

Passive statistics monitor on the 10GbE core receive interface, in the `user_clk` domain. It counts:
- valid receive words
- end-of-frame words
- bad frames
- overrun events

It also tracks the last and maximum frame length. Each counter output drives the `user_data_in` port of a `opb_register_simulink2ppc` software register, for example the rx-valid counter register. It never drives the receive handshake; it only observes it.

## Interface
Parameters:
- `CTR_W`, 32, width of each event counter; matches the 32-bit software-register data width.
- `LEN_W`, 16, width of the frame-length measurements in words.

Ports:
- `user_clk`  in  1  single clock; all logic is on the rising edge.
- `user_rst`  in  1  synchronous, active-high reset.
- `rx_valid`  in  1  a receive data word is present this cycle.
- `rx_end_of_frame`  in  1  qualifies `rx_valid`; the word is the last of its frame.
- `rx_bad_frame`  in  1  qualifies `rx_valid & rx_end_of_frame`; the frame is bad.
- `rx_overrun`  in  1  level overrun indication from the core.
- `ctr_en`  in  1  level; counting is enabled when 1.
- `ctr_clr`  in  1  level from a software register; its rising edge clears all statistics.
- `rxvldctr`  out  CTR_W  count of words with `rx_valid`.
- `rxeofctr`  out  CTR_W  count of words with `rx_valid & rx_end_of_frame`.
- `rxbadctr`  out  CTR_W  count of words with `rx_valid & rx_end_of_frame & rx_bad_frame`.
- `rxofctr`  out  CTR_W  count of rising edges of `rx_overrun`.
- `last_frame_len`  out  LEN_W  word count of the most recently completed frame.
- `max_frame_len`  out  LEN_W  largest completed frame length since the last clear.
- `ctr_wrapped`  out  4  sticky flags, one per counter, in the order {of, bad, eof, vld}; a flag sets when its counter wraps from all-ones to 0.

## Operation
- **Reset** (`user_rst`=1 at an edge): all outputs 0, FSM to IDLE, internal `ctr_clr_d`=0, `rx_overrun_d`=0, `frame_len`=0.
- **Clear pulse**: `clr_pulse = ctr_clr & ~ctr_clr_d`.
  - Zeroes all counters, `last_frame_len`, `max_frame_len` and `ctr_wrapped`.
  - Does not change the FSM or `frame_len`, so a frame in progress completes normally.
- **Priority**: `user_rst` > `clr_pulse` > increment. An event in the clear cycle is discarded.
- **Enable**: when `ctr_en`=0, the counters, length outputs and wrap flags hold their values. The FSM and `frame_len` keep tracking regardless of `ctr_en`.
- **Counters**: increment by 1, wrapping modulo 2^CTR_W. Each wrap sets its sticky bit in `ctr_wrapped`.
- **Overrun**: counts cycles where `rx_overrun & ~rx_overrun_d`. A held level counts once.
- **Frame FSM** states: IDLE, IN_FRAME.
  - IDLE, valid without eof: `frame_len` ← 1, go to IN_FRAME.
  - IDLE, valid with eof: completed length = 1, stay in IDLE.
  - IN_FRAME, valid without eof: `frame_len` +1, saturating at 2^LEN_W−1.
  - IN_FRAME, valid with eof: completed length = sat(`frame_len`+1), go to IDLE.
  - No valid: hold state.
- **On frame completion** (with `ctr_en`=1 and no clear that cycle): `last_frame_len` ← length. `max_frame_len` ← max(`max_frame_len`, length). Bad frames are also measured.

## Timing
- Every output is registered. An event sampled at edge N is visible after edge N.
- A rising edge of `ctr_clr` first sampled at edge N gives zeroed outputs after edge N.
- Back-to-back valid words every cycle are supported with no gaps. Throughput is 1 word per cycle.
- Level-to-edge detection for `ctr_clr` and `rx_overrun` uses the value registered at the previous edge. After reset, a `ctr_clr` or `rx_overrun` already high counts as a rising edge.
- There is no handshake. Inputs are sampled unconditionally every cycle.

## Structure
- Package `gbe_rx_stats_pkg`:
  - FSM state enum {IDLE, IN_FRAME}.
  - Defaults for `CTR_W` and `LEN_W`.
  - Wrap-flag bit index constants VLD=0, EOF=1, BAD=2, OF=3.
- Sub-module `gbe_rx_event_counter`:
  - Inputs: `user_clk`, `user_rst`, `clr`, `en`, `inc`.
  - Outputs: `count[CTR_W]` and sticky `wrapped`.
  - Instantiated four times.
- The top level holds the edge detectors, the frame FSM and the length logic.

## Test plan
- **Reset**: hold `user_rst` for 3 cycles with `rx_valid`=1 → all outputs 0; FSM IDLE.
- **Frame sequence**: frames of 5, 1 and 9 words back-to-back, `ctr_en`=1 → `rxvldctr`=15, `rxeofctr`=3, `last_frame_len`=9, `max_frame_len`=9.
- **Bad frame and overrun**: 4-word frame with `rx_bad_frame` on the eof word, plus `rx_overrun` high for 10 cycles → `rxbadctr`=1, `rxeofctr`=1, `rxofctr`=1.
- **Clear mid-frame**: raise `ctr_clr` during word 3 of a 6-word frame → counters 0 after that edge. At frame end, `rxvldctr`=3, `rxeofctr`=1, `last_frame_len`=6.
- **Wrap**: preload `rxvldctr` to 0xFFFFFFFE via force (or use `CTR_W`=4 from 14), then 3 valid words → count 1; `ctr_wrapped[0]`=1.
- **Enable**: `ctr_en`=0 during a 7-word frame → counters unchanged. After re-enabling, a following 2-word frame gives `last_frame_len`=2 and `rxvldctr` +2.
